// File: rtl/loop_mem_ctrl_if.sv
// Sample-RAM bus between the loop sequencer (master) and a single-port
// synchronous RAM (slave) with one cycle of read latency.
`timescale 1ns/1ps
interface loop_mem_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_we,
        output mem_re,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_we,
        input  mem_re,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/loop_mem_ctrl.sv
// Looper sample-memory sequencer: records samples on sample_tick, plays the
// stored loop back with wrap-around, and flags a full memory to the mode FSM.
`timescale 1ns/1ps
module loop_mem_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 16384
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rec_en,
    input  logic                play_en,
    input  logic                sample_tick,
    input  logic [DATA_W-1:0]   sample_in,
    loop_mem_ctrl_if.master     mem,
    output logic [DATA_W-1:0]   audio_out,
    output logic                audio_valid,
    output logic                loop_wrap,
    output logic                rec_done,
    output logic [ADDR_W:0]     loop_len
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REC,
        S_FULL,
        S_PLAY
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_WR = (ADDR_W+1)'(DEPTH - 1);

    state_t              state_reg, state_next;
    logic [ADDR_W:0]     wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W:0]     rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W:0]     loop_len_reg, loop_len_next;
    logic [DATA_W-1:0]   hold_reg, hold_next;
    logic                rd_pend_reg;
    logic                rec_done_reg, rec_done_next;

    logic                wr_fire;
    logic                rd_fire;
    logic                wrap_c;
    logic [ADDR_W:0]     addr_sel;

    // Read data is shown straight from the RAM on its valid cycle and latched
    // into hold_reg so the output keeps it until the next read returns.
    assign audio_out   = rd_pend_reg ? mem.mem_rdata : hold_reg;
    assign audio_valid = rd_pend_reg;
    assign loop_wrap   = wrap_c;
    assign rec_done    = rec_done_reg;
    assign loop_len    = loop_len_reg;

    assign mem.mem_we    = wr_fire;
    assign mem.mem_re    = rd_fire;
    assign mem.mem_addr  = addr_sel[ADDR_W-1:0];
    assign mem.mem_wdata = wr_fire ? sample_in : '0;

    always_comb begin
        state_next    = state_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        loop_len_next = loop_len_reg;
        hold_next     = audio_out;
        rec_done_next = 1'b0;
        wr_fire       = 1'b0;
        rd_fire       = 1'b0;
        wrap_c        = 1'b0;
        addr_sel      = '0;

        case (state_reg)
            S_IDLE: begin
                // Ticks arriving while still idle are dropped.
                if (rec_en) begin
                    state_next  = S_REC;
                    wr_ptr_next = '0;
                    hold_next   = '0;
                end else if (play_en) begin
                    state_next  = S_PLAY;
                    rd_ptr_next = '0;
                end
            end

            S_REC: begin
                if (!rec_en) begin
                    state_next    = S_IDLE;
                    loop_len_next = wr_ptr_reg;
                end else if (sample_tick) begin
                    wr_fire     = 1'b1;
                    addr_sel    = wr_ptr_reg;
                    wr_ptr_next = wr_ptr_reg + 1'b1;
                    if (wr_ptr_reg == LAST_WR) begin
                        state_next    = S_FULL;
                        loop_len_next = DEPTH_L;
                        rec_done_next = 1'b1;
                    end
                end
            end

            S_FULL: begin
                if (!rec_en) begin
                    state_next = S_IDLE;
                end
            end

            S_PLAY: begin
                if (loop_len_reg == '0) begin
                    hold_next = '0;
                end
                if (!play_en || rec_en) begin
                    state_next = S_IDLE;
                end else if (sample_tick && (loop_len_reg != '0)) begin
                    rd_fire  = 1'b1;
                    addr_sel = rd_ptr_reg;
                    if (rd_ptr_reg == loop_len_reg - 1'b1) begin
                        rd_ptr_next = '0;
                        wrap_c      = 1'b1;
                    end else begin
                        rd_ptr_next = rd_ptr_reg + 1'b1;
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            loop_len_reg <= '0;
            hold_reg     <= '0;
            rd_pend_reg  <= 1'b0;
            rec_done_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            loop_len_reg <= loop_len_next;
            hold_reg     <= hold_next;
            rd_pend_reg  <= rd_fire;
            rec_done_reg <= rec_done_next;
        end
    end

endmodule

// File: tb/tb_loop_mem_ctrl.sv
// Randomised bench for loop_mem_ctrl against a transaction-level looper model
// (stored loop array, play position, pending read) with a behavioural RAM.
`timescale 1ns/1ps
module tb_loop_mem_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 8;

    localparam int M_IDLE = 0;
    localparam int M_REC  = 1;
    localparam int M_FULL = 2;
    localparam int M_PLAY = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rec_en = 1'b0;
    logic              play_en = 1'b0;
    logic              sample_tick = 1'b0;
    logic [DATA_W-1:0] sample_in = '0;
    logic [DATA_W-1:0] audio_out;
    logic              audio_valid;
    logic              loop_wrap;
    logic              rec_done;
    logic [ADDR_W:0]   loop_len;

    loop_mem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mif ();

    loop_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rec_en      (rec_en),
        .play_en     (play_en),
        .sample_tick (sample_tick),
        .sample_in   (sample_in),
        .mem         (mif.master),
        .audio_out   (audio_out),
        .audio_valid (audio_valid),
        .loop_wrap   (loop_wrap),
        .rec_done    (rec_done),
        .loop_len    (loop_len)
    );

    always #5 clk = ~clk;

    // Synchronous RAM, one cycle read latency.
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    initial begin
        for (int i = 0; i < (1<<ADDR_W); i++) ram[i] = '0;
        mif.mem_rdata = '0;
    end
    always @(posedge clk) begin
        if (mif.mem_we) ram[mif.mem_addr] <= mif.mem_wdata;
        if (mif.mem_re) mif.mem_rdata <= ram[mif.mem_addr];
    end

    // Reference model state.
    int                mode;
    int                wcount;
    int                pos;
    int                llen;
    logic [DATA_W-1:0] held;
    bit                pend;
    logic [DATA_W-1:0] pend_data;
    bit                done_m;
    logic [DATA_W-1:0] mem_m [0:DEPTH-1];

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mode   = M_IDLE;
        wcount = 0;
        pos    = 0;
        llen   = 0;
        held   = '0;
        pend   = 1'b0;
        done_m = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check_val("rst_we",    32'(mif.mem_we),    0);
        check_val("rst_re",    32'(mif.mem_re),    0);
        check_val("rst_addr",  32'(mif.mem_addr),  0);
        check_val("rst_wdata", 32'(mif.mem_wdata), 0);
        check_val("rst_audio", 32'(audio_out),     0);
        check_val("rst_valid", 32'(audio_valid),   0);
        check_val("rst_wrap",  32'(loop_wrap),     0);
        check_val("rst_done",  32'(rec_done),      0);
        check_val("rst_len",   32'(loop_len),      0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic cycle(input bit rec, input bit play, input bit tick, input bit rst_mid);
        logic [DATA_W-1:0] smp;
        logic [DATA_W-1:0] e_audio, n_held, n_pdata;
        bit                e_we, e_re, e_wrap, n_done, n_pend;
        int                e_addr, n_mode;
        logic [DATA_W-1:0] e_wdata;

        smp = DATA_W'($urandom);
        @(negedge clk);
        rec_en      = rec;
        play_en     = play;
        sample_tick = tick;
        sample_in   = smp;
        #1;

        e_audio = pend ? pend_data : held;
        check_val("audio_valid", 32'(audio_valid), 32'(pend));
        check_val("audio_out",   32'(audio_out),   32'(e_audio));
        check_val("rec_done",    32'(rec_done),    32'(done_m));
        check_val("loop_len",    32'(loop_len),    32'(llen));

        e_we = 0; e_re = 0; e_wrap = 0; e_addr = 0; e_wdata = '0;
        n_mode = mode; n_held = e_audio; n_done = 0; n_pend = 0; n_pdata = '0;
        case (mode)
            M_IDLE: begin
                if (rec) begin
                    n_mode = M_REC; wcount = 0; n_held = '0;
                end else if (play) begin
                    n_mode = M_PLAY; pos = 0;
                end
            end
            M_REC: begin
                if (!rec) begin
                    n_mode = M_IDLE; llen = wcount;
                end else if (tick) begin
                    e_we = 1; e_addr = wcount; e_wdata = smp;
                    mem_m[wcount] = smp;
                    wcount++;
                    if (wcount == DEPTH) begin
                        n_mode = M_FULL; llen = DEPTH; n_done = 1;
                    end
                end
            end
            M_FULL: begin
                if (!rec) n_mode = M_IDLE;
            end
            default: begin
                if (llen == 0) n_held = '0;
                if (!play || rec) begin
                    n_mode = M_IDLE;
                end else if (tick && llen != 0) begin
                    e_re = 1; e_addr = pos; n_pend = 1; n_pdata = mem_m[pos];
                    if (pos == llen - 1) begin
                        e_wrap = 1; pos = 0;
                    end else begin
                        pos++;
                    end
                end
            end
        endcase

        check_val("mem_we",    32'(mif.mem_we),    32'(e_we));
        check_val("mem_re",    32'(mif.mem_re),    32'(e_re));
        check_val("mem_addr",  32'(mif.mem_addr),  32'(e_addr));
        check_val("mem_wdata", 32'(mif.mem_wdata), 32'(e_wdata));
        check_val("loop_wrap", 32'(loop_wrap),     32'(e_wrap));
        if (e_we) $display("wr addr=%0d data=%02h", e_addr, e_wdata);
        if (e_re) $display("rd addr=%0d data=%02h wrap=%0d", e_addr, n_pdata, e_wrap);

        if (rst_mid) begin
            $display("reset asserted mid-cycle");
            apply_reset();
        end else begin
            mode      = n_mode;
            held      = n_held;
            done_m    = n_done;
            pend      = n_pend;
            pend_data = n_pdata;
        end
    endtask

    bit rec_l, play_l;

    initial begin
        model_reset();
        apply_reset();

        // Tick on the rising request is dropped; then five samples recorded.
        cycle(1, 0, 1, 0);
        repeat (5) cycle(1, 0, 1, 0);
        cycle(1, 0, 0, 0);
        repeat (2) cycle(0, 0, 0, 0);

        // Three-sample loop played for seven ticks.
        cycle(1, 0, 0, 0);
        repeat (3) cycle(1, 0, 1, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        repeat (7) cycle(0, 1, 1, 0);
        repeat (3) cycle(0, 0, 0, 0);

        // Overfill: ten ticks into an eight-word memory.
        cycle(1, 0, 0, 0);
        repeat (10) cycle(1, 0, 1, 0);
        repeat (2) cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        repeat (10) cycle(0, 1, 1, 0);
        cycle(1, 1, 1, 0);
        repeat (2) cycle(0, 0, 0, 0);

        // Reset in the middle of a recording, then try to play.
        cycle(1, 0, 0, 0);
        repeat (3) cycle(1, 0, 1, 0);
        cycle(1, 0, 1, 1);
        cycle(0, 1, 0, 0);
        repeat (4) cycle(0, 1, 1, 0);
        cycle(0, 0, 0, 0);

        rec_l = 0;
        play_l = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) rec_l = ~rec_l;
            if ($urandom_range(0, 14) == 0) play_l = ~play_l;
            cycle(rec_l, play_l, $urandom_range(0, 2) == 0, $urandom_range(0, 399) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
